word_distributor16: RTL and testbench

Write-side counterpart of the 16-to-1 32-bit display/data selector. It accepts a stream of 32-bit words over a valid/ready handshake and distributes them into a bank of sixteen 32-bit holding registers. Words go either to an explicitly addressed slot or, in burst mode, to consecutive slots from a start index with wrap-around. The registered bank is exported flat, so the existing 16:1 selector can read any slot back out for display or checking.

---
 rtl/word_distributor16.sv | 177 +++++++++++++++++
 tb/tb_word_distributor16.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/word_distributor16.sv
// word_distributor16
// Distributes a valid/ready stream of 32-bit words into a bank of sixteen
// 32-bit holding registers. A word goes either to an addressed slot (mode 0)
// or, in burst mode, to consecutive slots from a start index with wrap-around.
// The bank is exported flat so a 16:1 selector can read any slot back.

module word_distributor16 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         mode,
    input  logic [3:0]   s,
    input  logic         start,
    input  logic [3:0]   len,
    input  logic         clr,
    output logic [511:0] o_flat,
    output logic [15:0]  slot_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [3:0]    ptr_r;
    logic [3:0]    remaining_r;
    logic [511:0]  bank_r;
    logic [15:0]   slot_valid_r;
    logic [15:0]   slot_valid_nxt_s;
    logic          in_ready_s;
    logic          busy_s;
    logic          done_s;
    logic          xfer_s;
    logic          launch_s;
    logic [3:0]    wr_idx_s;

    // A transfer needs both sides; burst launch only from IDLE in mode 1.
    assign xfer_s   = in_valid & in_ready_s;
    assign launch_s = (state_r == ST_IDLE) & mode & start;

    // Burst writes follow the running pointer, addressed writes follow s.
    assign wr_idx_s = (state_r == ST_BURST) ? ptr_r : s;

    // State register; reset aborts any burst straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE -> BURST on launch, BURST -> DONE on last word.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_nxt_s = ST_BURST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (xfer_s && (remaining_r == 4'd0)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; in_ready depends on state and mode only.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = ~mode;
                busy_s     = 1'b0;
                done_s     = 1'b0;
            end
            ST_BURST: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
                done_s     = 1'b0;
            end
            ST_DONE: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
                done_s     = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b0;
                done_s     = 1'b0;
            end
        endcase
    end

    // Burst pointer and remaining-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= 4'd0;
            remaining_r <= 4'd0;
        end else if (launch_s) begin
            ptr_r       <= s;
            remaining_r <= len;
        end else if ((state_r == ST_BURST) && xfer_s) begin
            ptr_r <= ptr_r + 4'd1;
            if (remaining_r != 4'd0) begin
                remaining_r <= remaining_r - 4'd1;
            end else begin
                remaining_r <= remaining_r;
            end
        end else begin
            ptr_r       <= ptr_r;
            remaining_r <= remaining_r;
        end
    end

    // Data bank: the accepted word lands in its slot; clr leaves data alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_r <= 512'd0;
        end else if (xfer_s) begin
            bank_r[{wr_idx_s, 5'd0} +: 32] <= in_data;
        end else begin
            bank_r <= bank_r;
        end
    end

    // Valid map: clr wipes everything, but a same-cycle write re-marks its slot.
    always_comb begin
        if (clr) begin
            slot_valid_nxt_s = 16'h0000;
        end else begin
            slot_valid_nxt_s = slot_valid_r;
        end
        if (xfer_s) begin
            slot_valid_nxt_s[wr_idx_s] = 1'b1;
        end else begin
            slot_valid_nxt_s = slot_valid_nxt_s;
        end
    end

    // Valid map register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_r <= 16'h0000;
        end else begin
            slot_valid_r <= slot_valid_nxt_s;
        end
    end

    assign in_ready   = in_ready_s;
    assign busy       = busy_s;
    assign done       = done_s;
    assign o_flat     = bank_r;
    assign slot_valid = slot_valid_r;

endmodule

// File: tb/tb_word_distributor16.sv
// Directed self-checking bench for word_distributor16.

module tb_word_distributor16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         mode;
    logic [3:0]   s;
    logic         start;
    logic [3:0]   len;
    logic         clr;
    logic [511:0] o_flat;
    logic [15:0]  slot_valid;
    logic         busy;
    logic         done;

    int passed_cnt = 0;
    int total_cnt  = 0;

    word_distributor16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mode       (mode),
        .s          (s),
        .start      (start),
        .len        (len),
        .clr        (clr),
        .o_flat     (o_flat),
        .slot_valid (slot_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slot(input int k);
        return o_flat[32*k +: 32];
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; mode = 1'b0;
        s = 4'd0; start = 1'b0; len = 4'd0; clr = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset mid-operation after a write
        in_valid = 1'b1; s = 4'd2; in_data = 32'h0000_0055;
        step();
        in_valid = 1'b0;
        chk("pre_reset_slot2", slot(2), 32'h0000_0055);
        rst_n = 1'b0;
        #1;
        chk("rst_flat", o_flat, 512'd0);
        chk("rst_valid", slot_valid, 16'h0000);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        step();

        // Addressed back-to-back writes
        mode = 1'b0; in_valid = 1'b1; s = 4'd3; in_data = 32'hDEAD_BEEF;
        step();
        chk("addr_first_slot3", slot(3), 32'hDEAD_BEEF);
        chk("addr_first_valid", slot_valid, 16'h0008);
        s = 4'd15; in_data = 32'h1234_5678;
        step();
        s = 4'd3; in_data = 32'h0000_0001;
        step();
        in_valid = 1'b0;
        chk("addr_slot3", slot(3), 32'h0000_0001);
        chk("addr_slot15", slot(15), 32'h1234_5678);
        chk("addr_valid", slot_valid, 16'h8008);

        // Burst with wrap: s=14 len=3
        mode = 1'b1; s = 4'd14; len = 4'd3; start = 1'b1;
        #1;
        chk("burst_idle_ready", in_ready, 1'b0);
        step();                               // start sampled (t0)
        start = 1'b0;
        chk("burst_busy", busy, 1'b1);
        chk("burst_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_data = 32'h0000_00A0;
        step();
        in_data = 32'h0000_00A1;
        step();
        in_data = 32'h0000_00A2;
        step();
        chk("burst_no_early_done", done, 1'b0);
        in_data = 32'h0000_00A3;
        step();                               // last accept (t0+4)
        in_valid = 1'b0;
        chk("burst_done_hi", done, 1'b1);
        chk("burst_done_ready", in_ready, 1'b0);
        step();
        chk("burst_done_lo", done, 1'b0);
        chk("burst_busy_lo", busy, 1'b0);
        chk("burst_slot14", slot(14), 32'h0000_00A0);
        chk("burst_slot15", slot(15), 32'h0000_00A1);
        chk("burst_slot0", slot(0), 32'h0000_00A2);
        chk("burst_slot1", slot(1), 32'h0000_00A3);
        chk("burst_valid", slot_valid, 16'hC00B);

        // Burst with gaps and a stray start
        s = 4'd5; len = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_00B0;
        step();
        in_valid = 1'b0;
        s = 4'd9; len = 4'd7; start = 1'b1;
        step();
        start = 1'b0;
        chk("gap_busy", busy, 1'b1);
        chk("gap_done0", done, 1'b0);
        step();
        chk("gap_done1", done, 1'b0);
        step();
        chk("gap_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_data = 32'h0000_00B1;
        step();
        in_valid = 1'b0;
        chk("gap_done_hi", done, 1'b1);
        step();
        chk("gap_done_lo", done, 1'b0);
        step(); step();
        chk("gap_no_second_done", done, 1'b0);
        chk("gap_idle_busy", busy, 1'b0);
        chk("gap_slot5", slot(5), 32'h0000_00B0);
        chk("gap_slot6", slot(6), 32'h0000_00B1);
        chk("gap_slot9", slot(9), 32'h0000_0000);
        chk("gap_valid", slot_valid, 16'hC06B);

        // Mode-1 idle gating
        mode = 1'b1; s = 4'd2; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; start = 1'b0;
        #1;
        chk("gate_ready", in_ready, 1'b0);
        step(); step();
        in_valid = 1'b0;
        chk("gate_slot2", slot(2), 32'h0000_0000);
        chk("gate_valid", slot_valid, 16'hC06B);
        chk("gate_busy", busy, 1'b0);

        // Fill every slot, then clr together with a write to slot 7
        mode = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s = k[3:0];
            in_data = 32'hC0DE_0000 + k;
            step();
        end
        in_valid = 1'b0;
        chk("fill_valid", slot_valid, 16'hFFFF);
        clr = 1'b1; in_valid = 1'b1; s = 4'd7; in_data = 32'h7777_7777;
        step();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_valid", slot_valid, 16'h0080);
        chk("clr_slot7", slot(7), 32'h7777_7777);
        for (int k = 0; k < 16; k++) begin
            if (k != 7) chk("clr_data_kept", slot(k), 32'hC0DE_0000 + k);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_only_valid", slot_valid, 16'h0000);

        // Reset in the middle of a 16-word burst
        mode = 1'b1; s = 4'd0; len = 4'd15; start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'h0000_00D0 + k;
            step();
        end
        chk("mid_busy", busy, 1'b1);
        chk("mid_valid", slot_valid, 16'h000F);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_flat", o_flat, 512'd0);
        chk("mid_rst_valid", slot_valid, 16'h0000);
        chk("mid_rst_ready_m1", in_ready, 1'b0);
        mode = 1'b0;
        #1;
        chk("mid_rst_ready_m0", in_ready, 1'b1);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_valid", slot_valid, 16'h0000);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
